// File: rtl/clock_divider_bank_if.sv
// clock_divider_bank_if: control and status bundle for clock_divider_bank.
//   en      per-channel count enable
//   wr_en   divisor write strobe
//   wr_ch   channel addressed by a write
//   wr_div  divisor value to write
//   sync    global phase restart (only when CLKDIV_SYNC_EN is defined)
//   out_clk per-channel 50 % divided clock
//   tick    per-channel one-cycle terminal-count strobe
//   pend    per-channel divisor write awaiting the next terminal count
// Modports: master drives the controls, slave is the divider bank.
interface clock_divider_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 30,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [CHANNELS-1:0] en;
  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [WIDTH-1:0]    wr_div;
`ifdef CLKDIV_SYNC_EN
  logic                sync;
`endif
  logic [CHANNELS-1:0] out_clk;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] pend;

`ifdef CLKDIV_SYNC_EN
  modport master (output en, wr_en, wr_ch, wr_div, sync,
                  input  out_clk, tick, pend);
  modport slave  (input  en, wr_en, wr_ch, wr_div, sync,
                  output out_clk, tick, pend);
`else
  modport master (output en, wr_en, wr_ch, wr_div,
                  input  out_clk, tick, pend);
  modport slave  (input  en, wr_en, wr_ch, wr_div,
                  output out_clk, tick, pend);
`endif
endinterface

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: bank of independent programmable clock dividers.
// Each channel counts 0..div, then wraps, toggles out_clk and pulses tick,
// giving out_clk period 2*(div+1) and tick period div+1. Divisor writes to
// an enabled channel are shadowed and applied at the next terminal count.
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  clock_divider_bank_if.slave (en, wr_en, wr_ch, wr_div, [sync],
//        out_clk, tick, pend)
// Optional feature: define CLKDIV_SYNC_EN to add the global sync restart.
module clock_divider_bank #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 30,
  parameter int DEFAULT_DIV = 5000000,
  parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input logic                 clk,
  input logic                 rst,
  clock_divider_bank_if.slave bus
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0]    cnt [CHANNELS];
  logic [WIDTH-1:0]    div [CHANNELS];
  logic [WIDTH-1:0]    shd [CHANNELS];
  logic [CHANNELS-1:0] pend_r;
  logic [CHANNELS-1:0] out_clk_r;
  logic [CHANNELS-1:0] tick_r;

  logic [CH_W-1:0]     wr_ch;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] tc;

  assign wr_ch = bus.wr_ch;

  // Out-of-range channel numbers match no index and are thereby ignored.
  always_comb begin
    wr_hit = '0;
    tc     = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = bus.wr_en && (32'(wr_ch) == i);
      tc[i]     = bus.en[i] && (cnt[i] == div[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
        div[i] <= DIV_RST;
        shd[i] <= DIV_RST;
      end
      pend_r    <= '0;
      out_clk_r <= '0;
      tick_r    <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
`ifdef CLKDIV_SYNC_EN
        if (bus.sync) begin
          // Restart phase on every channel; settle any outstanding divisor.
          cnt[i]       <= '0;
          out_clk_r[i] <= 1'b0;
          tick_r[i]    <= 1'b0;
          pend_r[i]    <= 1'b0;
          if (wr_hit[i]) begin
            div[i] <= bus.wr_div;
            shd[i] <= bus.wr_div;
          end else if (pend_r[i]) begin
            div[i] <= shd[i];
          end
        end else begin
`else
        begin
`endif
          if (tc[i]) begin
            // Terminal count: the only point where div may change while
            // counting, so cnt never exceeds div.
            cnt[i]       <= '0;
            out_clk_r[i] <= ~out_clk_r[i];
            tick_r[i]    <= 1'b1;
            pend_r[i]    <= 1'b0;
            if (wr_hit[i]) begin
              div[i] <= bus.wr_div;
              shd[i] <= bus.wr_div;
            end else if (pend_r[i]) begin
              div[i] <= shd[i];
            end
          end else if (bus.en[i]) begin
            cnt[i]    <= cnt[i] + WIDTH'(1);
            tick_r[i] <= 1'b0;
            if (wr_hit[i]) begin
              shd[i]    <= bus.wr_div;
              pend_r[i] <= 1'b1;
            end
          end else begin
            tick_r[i] <= 1'b0;
            if (wr_hit[i]) begin
              // Idle channel: take the divisor immediately and realign.
              div[i]    <= bus.wr_div;
              shd[i]    <= bus.wr_div;
              cnt[i]    <= '0;
              pend_r[i] <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign bus.out_clk = out_clk_r;
  assign bus.tick    = tick_r;
  assign bus.pend    = pend_r;

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank: directed self-checking bench for clock_divider_bank
// with three channels (channel 2 left disabled), 8-bit divisors and a reset
// divisor of 3. Define CLKDIV_SYNC_EN to also exercise the sync restart.
module tb_clock_divider_bank;
  localparam int CH = 3;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  clock_divider_bank_if #(.CHANNELS(CH), .WIDTH(W), .CH_W(2)) bus_if ();

  clock_divider_bank #(
    .CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(3), .CH_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] t, input logic [2:0] o,
                      input logic [2:0] p);
    check({tag, " tick"}, 32'(bus_if.tick), 32'(t));
    check({tag, " out_clk"}, 32'(bus_if.out_clk), 32'(o));
    check({tag, " pend"}, 32'(bus_if.pend), 32'(p));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] t;
    logic [2:0] o;
    rst           = 1'b1;
    bus_if.en     = '0;
    bus_if.wr_en  = 1'b0;
    bus_if.wr_ch  = '0;
    bus_if.wr_div = '0;
`ifdef CLKDIV_SYNC_EN
    bus_if.sync   = 1'b0;
`endif
    step();
    step();
    chk3("reset", 3'b000, 3'b000, 3'b000);
    rst = 1'b0;

    // Default divisor 3: tick every 4 cycles, out_clk period 8.
    bus_if.en = 3'b011;
    for (int k = 1; k <= 8; k++) begin
      step();
      t = (k % 4 == 0) ? 3'b011 : 3'b000;
      o = (((k / 4) % 2) == 1) ? 3'b011 : 3'b000;
      chk3("default", t, o, 3'b000);
    end

    // Enabled ch0: write 1 at cnt=1, held pending until the wrap.
    step();
    chk3("pre-wr", 3'b000, 3'b000, 3'b000);
    bus_if.wr_en = 1'b1; bus_if.wr_ch = 2'd0; bus_if.wr_div = 8'd1;
    step();
    bus_if.wr_en = 1'b0;
    chk3("pend0 a", 3'b000, 3'b000, 3'b001);
    step(); chk3("pend0 b", 3'b000, 3'b000, 3'b001);
    step(); chk3("wrap", 3'b011, 3'b011, 3'b000);
    step(); chk3("div1 a", 3'b000, 3'b011, 3'b000);
    step(); chk3("div1 b", 3'b001, 3'b010, 3'b000);
    step(); chk3("div1 c", 3'b000, 3'b010, 3'b000);
    step(); chk3("div1 d", 3'b011, 3'b001, 3'b000);

    // Disabled ch1: write 5 lands at once with cnt cleared.
    bus_if.en = 3'b000;
    bus_if.wr_en = 1'b1; bus_if.wr_ch = 2'd1; bus_if.wr_div = 8'd5;
    step();
    bus_if.wr_en = 1'b0;
    chk3("dis wr", 3'b000, 3'b001, 3'b000);
    bus_if.en = 3'b010;
    for (int m = 1; m <= 12; m++) begin
      step();
      t = (m % 6 == 0) ? 3'b010 : 3'b000;
      o = {1'b0, ((m / 6) % 2) == 1, 1'b1};
      chk3("div5", t, o, 3'b000);
    end

    // Drop enable mid-count, then resume from the held count.
    step();
    step();
    bus_if.en = 3'b000;
    step(); chk3("hold a", 3'b000, 3'b001, 3'b000);
    step(); chk3("hold b", 3'b000, 3'b001, 3'b000);
    bus_if.en = 3'b010;
    for (int m = 1; m <= 4; m++) begin
      step();
      t = (m == 4) ? 3'b010 : 3'b000;
      o = (m == 4) ? 3'b011 : 3'b001;
      chk3("resume", t, o, 3'b000);
    end

    // Write 0 to enabled ch0 (div 1, cnt 0): pending, then continuous tick.
    bus_if.en = 3'b001;
    bus_if.wr_en = 1'b1; bus_if.wr_ch = 2'd0; bus_if.wr_div = 8'd0;
    step();
    bus_if.wr_en = 1'b0;
    chk3("div0 pend", 3'b000, 3'b011, 3'b001);
    for (int m = 1; m <= 4; m++) begin
      step();
      o = {2'b01, (m % 2) == 0};
      chk3("div0", 3'b001, o, 3'b000);
    end

    // Out-of-range write while every channel is idle must not land anywhere.
    bus_if.en = 3'b000;
    step(); chk3("idle", 3'b000, 3'b011, 3'b000);
    bus_if.wr_en = 1'b1; bus_if.wr_ch = 2'd3; bus_if.wr_div = 8'd7;
    step();
    bus_if.wr_en = 1'b0;
    chk3("oor wr", 3'b000, 3'b011, 3'b000);
    bus_if.en = 3'b011;
    for (int m = 1; m <= 6; m++) begin
      step();
      t = {1'b0, m == 6, 1'b1};
      o = {1'b0, m != 6, (m % 2) == 0};
      chk3("oor run", t, o, 3'b000);
    end

`ifdef CLKDIV_SYNC_EN
    // ch0 at terminal count: write lands directly; phases now offset.
    bus_if.wr_en = 1'b1; bus_if.wr_ch = 2'd0; bus_if.wr_div = 8'd5;
    step();
    bus_if.wr_en = 1'b0;
    check("sy direct tick", 32'(bus_if.tick), 32'(3'b001));
    check("sy direct pend", 32'(bus_if.pend), 32'(3'b000));
    step();
    bus_if.wr_en = 1'b1; bus_if.wr_ch = 2'd1; bus_if.wr_div = 8'd5;
    step();
    bus_if.wr_en = 1'b0;
    check("sy pend1", 32'(bus_if.pend), 32'(3'b010));
    bus_if.sync = 1'b1;
    step();
    bus_if.sync = 1'b0;
    chk3("sync", 3'b000, 3'b000, 3'b000);
    for (int m = 1; m <= 6; m++) begin
      step();
      t = (m == 6) ? 3'b011 : 3'b000;
      o = (m == 6) ? 3'b011 : 3'b000;
      chk3("aligned", t, o, 3'b000);
    end
`endif

    // Reset mid-period discards a pending write and restores divisor 3.
    bus_if.en = 3'b011;
    bus_if.wr_en = 1'b1; bus_if.wr_ch = 2'd1; bus_if.wr_div = 8'd9;
    step();
    bus_if.wr_en = 1'b0;
    check("pre-rst pend", 32'(bus_if.pend), 32'(3'b010));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk3("mid rst", 3'b000, 3'b000, 3'b000);
    for (int k = 1; k <= 4; k++) begin
      step();
      t = (k == 4) ? 3'b011 : 3'b000;
      chk3("post rst", t, t, 3'b000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Parametrised bank of independent programmable clock dividers. It is the successor to the fixed 20 ms divider. Each channel produces a 50 %-duty divided clock and a one-cycle tick strobe, with its own enable and a runtime-writable divisor. New divisors are applied glitch-free at the channel's next terminal count. It sits between the board clock and the game-logic, debounce and display-scan blocks.

## Interface
- CHANNELS, 4, number of divider channels (1..16)
- WIDTH, 30, counter and divisor width in bits
- DEFAULT_DIV, 5000000, divisor loaded into every channel at reset
- CH_W, $clog2(CHANNELS) (min 1), width of channel select
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- en  input  CHANNELS  per-channel count enable
- wr_en  input  1  divisor write strobe
- wr_ch  input  CH_W  channel addressed by write
- wr_div  input  WIDTH  divisor value to write
- sync  input  1  global phase restart; present only with CLKDIV_SYNC_EN
- out_clk  output  CHANNELS  divided clock, toggles at each terminal count
- tick  output  CHANNELS  one-cycle strobe at each terminal count
- pend  output  CHANNELS  divisor write waiting for the next terminal count

## Operation
- Per channel state:
  - cnt[WIDTH]: counter.
  - div[WIDTH]: active divisor.
  - shd[WIDTH]: shadow divisor.
  - pend flag.
  - out_clk and tick registers.
- Reset state:
  - cnt=0, div=shd=DEFAULT_DIV, pend=0.
  - out_clk=0, tick=0 on every channel.
- Enabled counting (en[i]=1):
  - If cnt==div, this is the terminal count. Next state: cnt<=0, out_clk toggles, tick<=1.
  - Otherwise cnt<=cnt+1 and tick<=0.
  - Resulting periods: out_clk has period 2·(div+1) cycles; tick has period div+1 cycles.
- div=0: tick stays high continuously and out_clk toggles every cycle.
- Disabled (en[i]=0): cnt and out_clk hold, tick<=0, pend is retained.
- Divisor write (wr_en=1, wr_ch=i):
  - Channel disabled: div<=wr_div and cnt<=0 at the next edge; pend stays 0.
  - Channel enabled, not at terminal count: shd<=wr_div and pend<=1.
  - Channel enabled, at terminal count in the same cycle: the write lands directly as div<=wr_div; pend<=0.
  - A second write while pend=1 overwrites shd; only the last value is applied.
- On terminal count with pend=1: div<=shd and pend<=0.
- wr_ch >= CHANNELS: the write is ignored.
- Arithmetic is unsigned. cnt never exceeds div because a new div only takes effect with cnt=0.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- tick is high in the cycle where cnt==0 following the wrap. out_clk changes on the same edge.
- Write-to-effect latency:
  - Disabled channel: 1 cycle.
  - Enabled channel: at the next terminal count.
- en rising: counting resumes from the held cnt on the next edge.
- Reset mid-period: all state returns to reset values on the next edge. Pending writes are lost.

## Configuration
- CLKDIV_SYNC_EN:
  - Defined: the sync port exists. When sync=1, every channel gets cnt<=0, out_clk<=0 and tick<=0. Any pending shd is applied to div and pend clears, regardless of en.
  - A write in the same cycle as sync loads div directly for the addressed channel.
  - Priority order is rst > sync > normal counting.
- Not defined: no sync port. Channels phase-align only via rst or via a write to a disabled channel.

## Test plan
- Run with CHANNELS=2 and DEFAULT_DIV=3.
  - Reset, then en=2'b11 → tick high every 4 cycles.
  - out_clk period is 8 cycles with 4 high; the first toggle occurs 4 cycles after en rises.
- Enabled ch0: write wr_div=1 at cnt=1.
  - pend[0]=1 until the wrap; then tick every 2 cycles.
  - pend[0] returns to 0 on the wrap edge.
- Disabled ch1: write 5 → cnt is 0 next cycle.
  - After en[1]=1, tick every 6 cycles.
  - Drop en mid-count → tick=0 and out_clk holds.
- Write 0 to ch0 → after the wrap, tick stays high continuously and out_clk toggles each cycle.
- Write to wr_ch=2 (out of range) → no state change on either channel.
- Build with CLKDIV_SYNC_EN.
  - Offset phases, assert sync for 1 cycle → both cnt=0 and out_clk=0.
  - The ticks then coincide whenever divisors are equal.
